// File: rtl/sel_mux.sv
// sel_mux: N-to-1 single-bit multiplexer with a one-hot select decode.
// Provides a zero-latency selected bit and a registered copy with load enable.
module sel_mux #(
  parameter int P_SEL_WIDTH = 3
) (
  input  logic                        i_w_clk,
  input  logic                        i_w_reset,
  input  logic [2**P_SEL_WIDTH-1:0]   i_w_in,
  input  logic [P_SEL_WIDTH-1:0]      i_w_sel,
  input  logic                        i_w_en,
  output logic                        o_w_out,
  output logic                        o_w_out_q,
  output logic [2**P_SEL_WIDTH-1:0]   o_w_sel_onehot
);

  localparam int N = 2**P_SEL_WIDTH;

  localparam logic [N-1:0] ONE = N'(1);

  logic out_d;
  logic out_q;

  // Select the addressed bit; an unknown select propagates X.
  always_comb begin
    o_w_out = i_w_in[i_w_sel];
  end

  // Decode the select into a one-hot vector.
  always_comb begin
    o_w_sel_onehot = ONE << i_w_sel;
  end

  // Load the selected bit when enabled, otherwise hold.
  always_comb begin
    out_d = out_q;
    if (i_w_en) out_d = o_w_out;
  end

  // Output flop; reset clears it immediately.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) out_q <= 1'b0;
    else           out_q <= out_d;
  end

  assign o_w_out_q = out_q;

endmodule

// File: tb/tb_sel_mux.sv
// tb_sel_mux: directed table-driven bench for sel_mux.
// Covers select widths 1, 3 and 4 plus the registered path.
module tb_sel_mux;

  logic clk = 1'b0;
  logic rst;

  logic [7:0] in3;
  logic [2:0] sel3;
  logic       en3;
  logic       out3, out3_q;
  logic [7:0] oh3;

  logic [1:0] in1;
  logic [0:0] sel1;
  logic       out1, out1_q;
  logic [1:0] oh1;

  logic [15:0] in4;
  logic [3:0]  sel4;
  logic        out4, out4_q;
  logic [15:0] oh4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sel_mux #(.P_SEL_WIDTH(3)) u3 (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_in(in3), .i_w_sel(sel3),
    .i_w_en(en3), .o_w_out(out3), .o_w_out_q(out3_q),
    .o_w_sel_onehot(oh3)
  );

  sel_mux #(.P_SEL_WIDTH(1)) u1 (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_in(in1), .i_w_sel(sel1),
    .i_w_en(1'b1), .o_w_out(out1), .o_w_out_q(out1_q),
    .o_w_sel_onehot(oh1)
  );

  sel_mux #(.P_SEL_WIDTH(4)) u4 (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_in(in4), .i_w_sel(sel4),
    .i_w_en(1'b1), .o_w_out(out4), .o_w_out_q(out4_q),
    .o_w_sel_onehot(oh4)
  );

  typedef struct {
    logic [7:0] in;
    logic [2:0] sel;
    logic       exp;
    logic [7:0] oh;
  } vec_t;

  vec_t tbl[128];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] ohx [8];
    logic [7:0] w;
    ohx = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    for (int i = 0; i < 8; i++) begin
      w = 8'h01 << i;
      for (int j = 0; j < 8; j++) begin
        tbl[i*8+j].in  = w;
        tbl[i*8+j].sel = 3'(j);
        tbl[i*8+j].exp = (i == j);
        tbl[i*8+j].oh  = ohx[j];
        tbl[64+i*8+j].in  = ~w;
        tbl[64+i*8+j].sel = 3'(j);
        tbl[64+i*8+j].exp = (i != j);
        tbl[64+i*8+j].oh  = ohx[j];
      end
    end

    rst = 1'b0;
    en3 = 1'b0;
    in3 = 8'h00;
    sel3 = 3'd0;
    in1 = 2'b00;
    sel1 = 1'b0;
    in4 = 16'h0;
    sel4 = 4'd0;

    // Reset asserted between edges clears the flop immediately.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_q", {31'b0, out3_q}, 32'd0);
    chk("reset_q_w1", {31'b0, out1_q}, 32'd0);
    chk("reset_q_w4", {31'b0, out4_q}, 32'd0);
    @(posedge clk);
    #1;
    chk("reset_hold_q", {31'b0, out3_q}, 32'd0);

    // Combinational walking-one / walking-zero table, width 3.
    for (int k = 0; k < 128; k++) begin
      in3 = tbl[k].in;
      sel3 = tbl[k].sel;
      #5;
      chk($sformatf("comb_%0d", k), {31'b0, out3}, {31'b0, tbl[k].exp});
      if (k < 8) begin
        chk($sformatf("onehot_%0d", k), {24'b0, oh3}, {24'b0, tbl[k].oh});
        chk($sformatf("onehot_cnt_%0d", k), $countones(oh3), 32'd1);
      end
    end

    // Registered load with enable.
    @(negedge clk);
    rst = 1'b0;
    in3 = 8'h20;
    sel3 = 3'd5;
    en3 = 1'b1;
    @(posedge clk);
    #1;
    chk("load_q", {31'b0, out3_q}, 32'd1);

    // Hold while disabled, even though the selected bit is now 0.
    @(negedge clk);
    en3 = 1'b0;
    sel3 = 3'd0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_q_%0d", c), {31'b0, out3_q}, 32'd1);
    end
    chk("hold_comb", {31'b0, out3}, 32'd0);

    // Mid-operation reset between edges.
    @(negedge clk);
    sel3 = 3'd5;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_q", {31'b0, out3_q}, 32'd0);
    chk("mid_rst_comb", {31'b0, out3}, 32'd1);
    en3 = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_hold", {31'b0, out3_q}, 32'd0);

    // Release: next edge loads again.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_load", {31'b0, out3_q}, 32'd1);

    // Enabled load of a zero clears the flop.
    @(negedge clk);
    sel3 = 3'd4;
    @(posedge clk);
    #1;
    chk("load_zero", {31'b0, out3_q}, 32'd0);

    // Width 1 walking-one sweep.
    for (int i = 0; i < 2; i++) begin
      in1 = 2'b01 << i;
      for (int j = 0; j < 2; j++) begin
        sel1 = 1'(j);
        #5;
        chk($sformatf("w1_%0d_%0d", i, j), {31'b0, out1},
            (i == j) ? 32'd1 : 32'd0);
      end
    end

    // Width 4 walking-one sweep.
    for (int i = 0; i < 16; i++) begin
      in4 = 16'h0001 << i;
      for (int j = 0; j < 16; j++) begin
        sel4 = 4'(j);
        #1;
        chk($sformatf("w4_%0d_%0d", i, j), {31'b0, out4},
            (i == j) ? 32'd1 : 32'd0);
      end
    end
    sel4 = 4'd15;
    #1;
    chk("w4_onehot_top", {16'b0, oh4}, 32'h8000);
    sel1 = 1'b1;
    #1;
    chk("w1_onehot_top", {30'b0, oh1}, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sel_mux.md
Name: sel_mux

Overview:
- Parameterised N-to-1 single-bit multiplexer, N = 2**P_SEL_WIDTH.
- Combinational output selects bit i_w_in[i_w_sel] with zero latency; this is the primary datapath output used by bit-select logic.
- A registered copy of the selected bit is also provided, clocked on i_w_clk, with asynchronous active-high reset, for timing-closure use downstream.

Parameters:
- P_SEL_WIDTH, 3, select width in bits; input vector width is 2**P_SEL_WIDTH. Legal range 1..8.

Ports:
- i_w_clk  input  1  clock, rising-edge active
- i_w_reset  input  1  asynchronous active-high reset
- i_w_in  input  2**P_SEL_WIDTH  data bits; bit k is routed when select equals k
- i_w_sel  input  P_SEL_WIDTH  unsigned select index
- i_w_en  input  1  load enable for the registered output
- o_w_out  output  1  combinational selected bit
- o_w_out_q  output  1  registered selected bit
- o_w_sel_onehot  output  2**P_SEL_WIDTH  one-hot decode of i_w_sel (combinational)

Behaviour:
- Combinational path:
  - o_w_out = i_w_in[i_w_sel] for every select value 0..2**P_SEL_WIDTH-1.
  - o_w_out is purely combinational: no dependence on clock, reset or enable, and it settles within the same delta/time step as input changes.
- Select range: every select code is valid because the input width equals 2**P_SEL_WIDTH. There is no out-of-range case and no default/fill value.
- Unknown select (X/Z on any i_w_sel bit): o_w_out and o_w_sel_onehot are X in simulation; no priority or default bit is substituted.
- One-hot decode: o_w_sel_onehot[k] = 1 exactly when i_w_sel == k; all other bits are 0. Exactly one bit is set for any known select value.
- Registered path:
  - i_w_reset high forces o_w_out_q = 0 immediately, asynchronously, independent of the clock.
  - While i_w_reset is high, o_w_out_q holds 0 regardless of clock edges.
  - On a rising i_w_clk edge with i_w_reset low and i_w_en = 1: o_w_out_q <= i_w_in[i_w_sel], giving 1-cycle latency from the sampled inputs.
  - When i_w_en = 0, o_w_out_q holds its previous value.
  - Reset deassertion takes effect at the next rising edge; there is no synchronisation inside the block.
- Reset asserted mid-operation: o_w_out_q clears at once, while o_w_out keeps following its inputs.
- Reset values:
  - o_w_out_q = 0.
  - o_w_out and o_w_sel_onehot are not reset; they always reflect the current inputs.
- No state machine; the only state element is the single o_w_out_q flop.

Test Plan:
- Walking-one exhaustive sweep (P_SEL_WIDTH = 3): for i = 0..7, set i_w_in = 1<<i; for each j = 0..7, apply i_w_sel = j and wait 5 ns. Required: o_w_out == (i==j), compared with case equality and no X. 64 checks.
- Walking-zero sweep: i_w_in = ~(1<<i) for all i, j -> o_w_out == (i!=j).
- One-hot decode: i_w_sel = 0..7 -> o_w_sel_onehot = 8'h01, 8'h02, ..., 8'h80 in order, with exactly one bit set.
- Registered path:
  - Step 1: assert i_w_reset -> o_w_out_q = 0 immediately, with no clock edge.
  - Step 2: release reset, set i_w_in = 8'h20, i_w_sel = 5, i_w_en = 1 -> o_w_out_q = 1 after one rising edge.
  - Step 3: drop i_w_en and change i_w_sel to 0 -> o_w_out_q stays 1 over 3 edges.
- Mid-operation reset: with o_w_out_q = 1, pulse i_w_reset between clock edges -> o_w_out_q = 0 within the same time step. o_w_out is unaffected and still equals i_w_in[i_w_sel].
- Width sweep: repeat the walking-one test for P_SEL_WIDTH = 1 (2 inputs) and P_SEL_WIDTH = 4 (16 inputs) -> all 4 and 256 checks pass.
